// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two requesters access to one
// synchronous single-port RAM. Each transaction runs IDLE -> ACCESS -> RESP,
// so it takes three cycles.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req0/req1             request, held until the matching ack
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           word address
//   wdata0/wdata1         write data
//   ack0/ack1             one-cycle completion pulse
//   rdata, rvalid         read data, valid together with the ack of a read
//   busy                  high whenever a transaction is in flight
//   ram_addr, ram_din     RAM address and write data (hold between accesses)
//   ram_writeEn, ram_read RAM strobes, asserted only in ACCESS
//   ram_dout              RAM registered read data
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_writeEn,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_last_grant;
    logic                  r_win;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic                  r_ram_we;
    logic                  r_ram_rd;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_rvalid;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_win;
    logic                  w_we_sel;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_wdata_sel;
    logic                  w_load;
    logic                  w_ram_we_nxt;
    logic                  w_ram_rd_nxt;
    logic                  w_ack0_nxt;
    logic                  w_ack1_nxt;
    logic                  w_rvalid_nxt;
    logic                  w_busy_nxt;

    // Round-robin pick: a lone requester wins; on contention the port that
    // did not win last time gets it.
    always_comb begin
        w_win       = (req0 && req1) ? ~r_last_grant : req1;
        w_we_sel    = w_win ? we1    : we0;
        w_addr_sel  = w_win ? addr1  : addr0;
        w_wdata_sel = w_win ? wdata1 : wdata0;
    end

    // Next state and next registered outputs; outputs are computed one cycle
    // ahead so they line up with the state they belong to.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_ram_we_nxt = 1'b0;
        w_ram_rd_nxt = 1'b0;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_rvalid_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt  = ST_ACCESS;
                    w_load       = 1'b1;
                    w_ram_we_nxt = w_we_sel;
                    w_ram_rd_nxt = ~w_we_sel;
                end
            end
            ST_ACCESS: begin
                w_state_nxt  = ST_RESP;
                w_ack0_nxt   = ~r_win;
                w_ack1_nxt   = r_win;
                w_rvalid_nxt = ~r_we;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_win        <= 1'b0;
            r_we         <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we     <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rvalid     <= 1'b0;
            r_busy       <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ram_we <= w_ram_we_nxt;
            r_ram_rd <= w_ram_rd_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_busy   <= w_busy_nxt;
            if (w_load) begin
                r_win        <= w_win;
                r_we         <= w_we_sel;
                r_last_grant <= w_win;
                r_ram_addr   <= w_addr_sel;
                r_ram_din    <= w_wdata_sel;
            end
            if (r_rvalid) begin
                r_rdata <= ram_dout;
            end
        end
    end

    // RAM data arrives during RESP, so it is passed straight through while
    // rvalid is high and the captured copy is shown otherwise.
    assign rdata       = r_rvalid ? ram_dout : r_rdata;
    assign rvalid      = r_rvalid;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign busy        = r_busy;
    assign ram_addr    = r_ram_addr;
    assign ram_din     = r_ram_din;
    assign ram_writeEn = r_ram_we;
    assign ram_read    = r_ram_rd;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_ram_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          ack0, ack1, rvalid, busy, ram_writeEn, ram_read;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_writeEn(ram_writeEn),
        .ram_read(ram_read), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM attached to the arbiter.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_writeEn) mem[ram_addr] <= ram_din;
        if (ram_read)    ram_dout <= mem[ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: phase 0 = free, 1 = access, 2 = response.
    int            m_phase;
    logic          m_last, m_win, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_hold_rdata;
    logic [DW-1:0] ref_mem [DEPTH];

    always @(negedge clk) begin
        logic          e_ack0, e_ack1, e_rv, e_busy, e_wen, e_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din, e_rdata;
        e_ack0 = 0; e_ack1 = 0; e_rv = 0; e_busy = 0; e_wen = 0; e_rd = 0;
        e_addr = '0; e_din = '0; e_rdata = '0;
        if (!rst) begin
            e_addr  = m_addr;
            e_din   = m_wdata;
            e_rdata = m_hold_rdata;
            if (m_phase == 1) begin
                e_busy = 1; e_wen = m_we; e_rd = !m_we;
            end else if (m_phase == 2) begin
                e_busy = 1; e_ack0 = !m_win; e_ack1 = m_win; e_rv = !m_we;
                if (!m_we) e_rdata = ref_mem[m_addr];
            end
        end
        chk("ack0", 32'(ack0), 32'(e_ack0));
        chk("ack1", 32'(ack1), 32'(e_ack1));
        chk("rvalid", 32'(rvalid), 32'(e_rv));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ram_writeEn", 32'(ram_writeEn), 32'(e_wen));
        chk("ram_read", 32'(ram_read), 32'(e_rd));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_din", 32'(ram_din), 32'(e_din));
        chk("rdata", 32'(rdata), 32'(e_rdata));
        chk("ack_exclusive", 32'(ack0 & ack1), 0);
        if (rst) begin
            m_phase = 0; m_last = 1; m_win = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_hold_rdata = '0;
        end else begin
            case (m_phase)
                0: if (req[0] || req[1]) begin
                    m_win   = (req[0] && req[1]) ? !m_last : req[1];
                    m_we    = we[m_win];
                    m_addr  = addr[m_win];
                    m_wdata = wdata[m_win];
                    m_last  = m_win;
                    m_phase = 1;
                end
                1: begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    m_phase = 2;
                end
                default: begin
                    if (!m_we) m_hold_rdata = ref_mem[m_addr];
                    m_phase = 0;
                end
            endcase
        end
    end

    // Results of the last do_txn call.
    logic [DW-1:0] t_rd, t_din;
    logic [AW-1:0] t_acc_addr, t_resp_addr;
    logic          t_we, t_rdst, t_rv;
    int            t_lat;

    // One request from port p; captures ACCESS-cycle strobes and RESP data.
    task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit scr);
        bit got = 0;
        @(posedge clk); #1;
        we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1;
        t_lat = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (c == 2) begin
                t_acc_addr = ram_addr; t_din = ram_din; t_we = ram_writeEn; t_rdst = ram_read;
                if (scr) begin #1 addr[p] = ~a; end
            end
            if ((p == 0) ? ack0 : ack1) begin
                got = 1; t_lat = c; t_rd = rdata; t_rv = rvalid; t_resp_addr = ram_addr;
            end
        end
        chk("txn_timeout", 32'(got), 1);
        @(posedge clk); #1 req[p] = 0;
    endtask

    // Random requester: drops after its ack, may scramble fields mid-flight.
    task automatic rand_port(input int p, input int n);
        logic seen;
        for (int c = 0; c < n + 60; c++) begin
            @(negedge clk);
            seen = (p == 0) ? ack0 : ack1;
            @(posedge clk); #1;
            if (req[p] && seen) begin
                req[p] = 0;
            end else if (!req[p] && c < n && $urandom_range(0, 2) == 0) begin
                we[p]    = 1'($urandom_range(0, 1));
                addr[p]  = AW'($urandom_range(0, DEPTH - 1));
                wdata[p] = DW'($urandom);
                req[p]   = 1;
            end else if (req[p] && m_phase != 0 && $urandom_range(0, 3) == 0) begin
                we[p]    = 1'($urandom_range(0, 1));
                addr[p]  = AW'($urandom);
                wdata[p] = DW'($urandom);
            end
        end
        chk("rand_drain", 32'(req[p]), 0);
    endtask

    initial begin
        int seq[$];
        int tim[$];
        rst = 1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; we[p] = 0; addr[p] = '0; wdata[p] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        @(posedge clk); #3 rst = 0;

        // Write then read back through the other port.
        do_txn(0, 1, 6'd5, 16'd11, 0);
        chk("w_lat", 32'(t_lat), 3);
        chk("w_wen", 32'(t_we), 1);
        chk("w_rd", 32'(t_rdst), 0);
        chk("w_addr", 32'(t_acc_addr), 5);
        chk("w_din", 32'(t_din), 11);
        chk("w_rvalid", 32'(t_rv), 0);
        do_txn(1, 0, 6'd5, 16'd0, 0);
        chk("r_lat", 32'(t_lat), 3);
        chk("r_rd", 32'(t_rdst), 1);
        chk("r_wen", 32'(t_we), 0);
        chk("r_rvalid", 32'(t_rv), 1);
        chk("r_rdata", 32'(t_rd), 11);

        // Fill every address, read it all back.
        for (int i = 0; i < int'(DEPTH); i++) do_txn(0, 1, AW'(i), DW'(2 * i + 1), 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_txn(1, 0, AW'(i), 16'd0, 0);
            chk("fill_rdata", 32'(t_rd), 32'(2 * i + 1));
        end

        // Address changed while the read is in flight.
        do_txn(1, 0, 6'd5, 16'd0, 1);
        chk("scr_acc_addr", 32'(t_acc_addr), 5);
        chk("scr_resp_addr", 32'(t_resp_addr), 5);
        chk("scr_rdata", 32'(t_rd), 11);

        // Both requesters held from reset: grants alternate every 3 cycles.
        @(posedge clk); #1 rst = 1;
        we[0] = 0; addr[0] = 6'd3; we[1] = 0; addr[1] = 6'd4;
        req[0] = 1; req[1] = 1;
        @(posedge clk); #3 rst = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack0) begin seq.push_back(0); tim.push_back(c); end
            if (ack1) begin seq.push_back(1); tim.push_back(c); end
        end
        @(posedge clk); #1 req[0] = 0; req[1] = 0;
        chk("rr_count", 32'(seq.size()), 4);
        for (int k = 0; k < seq.size() && k < 4; k++) begin
            chk("rr_grant", 32'(seq[k]), 32'(k % 2));
            chk("rr_time", 32'(tim[k]), 32'(3 * (k + 1)));
        end

        // Reset during the ACCESS of a write aborts it; port 0 wins afterwards.
        do_txn(0, 0, 6'd3, 16'd0, 0);
        @(posedge clk); #1 we[0] = 1; addr[0] = 6'd7; wdata[0] = 16'h55; req[0] = 1;
        @(negedge clk);
        @(posedge clk); #3 rst = 1;
        #1;
        chk("abort_wen", 32'(ram_writeEn), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack0", 32'(ack0), 0);
        chk("abort_addr", 32'(ram_addr), 0);
        chk("abort_din", 32'(ram_din), 0);
        we[0] = 0; req[1] = 1; we[1] = 0; addr[1] = 6'd9;
        @(posedge clk);
        @(posedge clk); #3 rst = 0;
        seq.delete(); tim.delete();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                seq.push_back(ack1 ? 1 : 0); tim.push_back(c);
                if (seq.size() == 1) t_rd = rdata;
            end
        end
        @(posedge clk); #1 req[0] = 0; req[1] = 0;
        chk("post_rst_count", 32'(seq.size()), 4);
        if (seq.size() > 0) begin
            chk("post_rst_first", 32'(seq[0]), 0);
            chk("post_rst_lat", 32'(tim[0]), 3);
            chk("post_rst_rdata", 32'(t_rd), 15);
        end

        // Randomized traffic from both ports.
        fork
            rand_port(0, 1500);
            rand_port(1, 1500);
        join
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
